// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-ported data_mem between the
// load/store unit (port 0) and the debug/program-loader port (port 1).
module dmem_arbiter #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int MAX_WAIT    = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,

    input  logic             p0_req_i,
    input  logic             p0_we_i,
    input  logic [2:0]       p0_width_i,
    input  logic [WIDTH-1:0] p0_addr_i,
    input  logic [WIDTH-1:0] p0_wdata_i,
    output logic             p0_gnt_o,
    output logic             p0_rvalid_o,
    output logic [WIDTH-1:0] p0_rdata_o,
    output logic             p0_err_o,

    input  logic             p1_req_i,
    input  logic             p1_we_i,
    input  logic [2:0]       p1_width_i,
    input  logic [WIDTH-1:0] p1_addr_i,
    input  logic [WIDTH-1:0] p1_wdata_i,
    output logic             p1_gnt_o,
    output logic             p1_rvalid_o,
    output logic [WIDTH-1:0] p1_rdata_o,
    output logic             p1_err_o,
    input  logic             p1_lock_i,

    output logic             mem_we_o,
    output logic [2:0]       mem_width_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    // Access-width codes (RISC-V funct3 style: lb/lh/lw)
    localparam logic [2:0] W_8S  = 3'b000;
    localparam logic [2:0] W_16S = 3'b001;
    localparam logic [2:0] W_32  = 3'b010;

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_wait_cnt;
    logic             w_wait_full;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any;

    logic             w_sel_we;
    logic [2:0]       w_sel_width;
    logic [WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0] w_sel_wdata;
    logic             w_err;

    logic             r_rvalid0;
    logic             r_rvalid1;
    logic             r_err0;
    logic             r_err1;
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;

    assign w_wait_full = (r_wait_cnt == CW'(MAX_WAIT));

    // Grant decision and next state; nothing is granted while in reset
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        if (!reset_i) begin
            case (r_state)
                ST_ARB: begin
                    if (p1_req_i && (w_wait_full || !p0_req_i)) begin
                        w_gnt1 = 1'b1;
                    end else if (p0_req_i) begin
                        w_gnt0 = 1'b1;
                    end
                    if (w_gnt1 && p1_lock_i) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    w_gnt1 = p1_req_i;
                    if (!p1_lock_i) begin
                        w_state_nxt = ST_ARB;
                    end
                end
                default: w_state_nxt = ST_ARB;
            endcase
        end
    end

    assign w_any       = w_gnt0 | w_gnt1;
    assign w_sel_we    = w_gnt1 ? p1_we_i    : p0_we_i;
    assign w_sel_width = w_gnt1 ? p1_width_i : p0_width_i;
    assign w_sel_addr  = w_gnt1 ? p1_addr_i  : p0_addr_i;
    assign w_sel_wdata = w_gnt1 ? p1_wdata_i : p0_wdata_i;

    // Alignment, width-code and range check of the selected request
    always_comb begin
        w_err = 1'b0;
        case (w_sel_width)
            W_32:    w_err = (w_sel_addr[1:0] != 2'b00);
            W_16S:   w_err = w_sel_addr[0];
            W_8S:    w_err = 1'b0;
            default: w_err = 1'b1;
        endcase
        if (w_sel_addr >= WIDTH'(DEPTH_BYTES)) begin
            w_err = 1'b1;
        end
    end

    assign p0_gnt_o    = w_gnt0;
    assign p1_gnt_o    = w_gnt1;
    assign mem_we_o    = w_any & w_sel_we & ~w_err;
    assign mem_width_o = w_any ? w_sel_width : 3'b000;
    assign mem_addr_o  = w_any ? w_sel_addr  : '0;
    assign mem_wdata_o = w_any ? w_sel_wdata : '0;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Port-1 starvation counter; frozen while port 1 owns the memory
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wait_cnt <= '0;
        end else if (!p1_req_i || w_gnt1) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ARB && !w_wait_full) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    // Response registers: one-cycle rvalid, rdata held until next response
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            r_err0    <= w_gnt0 & w_err;
            r_err1    <= w_gnt1 & w_err;
            if (w_gnt0) begin
                r_rdata0 <= (w_err || w_sel_we) ? '0 : mem_rdata_i;
            end
            if (w_gnt1) begin
                r_rdata1 <= (w_err || w_sel_we) ? '0 : mem_rdata_i;
            end
        end
    end

    // A reset arriving in the response cycle drops that response
    assign p0_rvalid_o = r_rvalid0 & ~reset_i;
    assign p1_rvalid_o = r_rvalid1 & ~reset_i;
    assign p0_err_o    = r_err0 & ~reset_i;
    assign p1_err_o    = r_err1 & ~reset_i;
    assign p0_rdata_o  = r_rdata0;
    assign p1_rdata_o  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: vector table, directed corner sequences
// and randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

    localparam int DEPTH = 1024;
    localparam int MAXW  = 4;
    localparam logic [2:0] W8  = 3'b000;
    localparam logic [2:0] W16 = 3'b001;
    localparam logic [2:0] W32 = 3'b010;

    logic        clk;
    logic        reset_i;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i, p1_lock_i;
    logic [2:0]  p0_width_i, p1_width_i;
    logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
    logic        p0_gnt_o, p0_rvalid_o, p0_err_o;
    logic        p1_gnt_o, p1_rvalid_o, p1_err_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        mem_we_o;
    logic [2:0]  mem_width_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.WIDTH(32), .DEPTH_BYTES(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_width_i(p0_width_i),
        .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
        .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
        .p0_rdata_o(p0_rdata_o), .p0_err_o(p0_err_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_width_i(p1_width_i),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
        .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
        .p1_rdata_o(p1_rdata_o), .p1_err_o(p1_err_o),
        .p1_lock_i(p1_lock_i),
        .mem_we_o(mem_we_o), .mem_width_o(mem_width_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed little-endian data memory seen by the DUT
    logic [7:0] mem [DEPTH];
    // Model's private copy, updated only by predicted stores
    logic [7:0] ref_mem [DEPTH];

    function automatic logic [31:0] ld(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [2:0] w);
        case (w)
            W32:     return {b3, b2, b1, b0};
            W16:     return {{16{b1[7]}}, b1, b0};
            W8:      return {{24{b0[7]}}, b0};
            default: return 32'h0;
        endcase
    endfunction

    logic [9:0] ra;
    assign ra = (mem_width_o == W32) ? {mem_addr_o[9:2], 2'b00} :
                (mem_width_o == W16) ? {mem_addr_o[9:1], 1'b0} : mem_addr_o[9:0];
    assign mem_rdata_i = ld(mem[ra], mem[ra + 10'd1], mem[ra + 10'd2],
                            mem[ra + 10'd3], mem_width_o);

    always @(posedge clk) begin
        if (mem_we_o) begin
            case (mem_width_o)
                W32: begin
                    mem[ra]         <= mem_wdata_o[7:0];
                    mem[ra + 10'd1] <= mem_wdata_o[15:8];
                    mem[ra + 10'd2] <= mem_wdata_o[23:16];
                    mem[ra + 10'd3] <= mem_wdata_o[31:24];
                end
                W16: begin
                    mem[ra]         <= mem_wdata_o[7:0];
                    mem[ra + 10'd1] <= mem_wdata_o[15:8];
                end
                default: mem[ra] <= mem_wdata_o[7:0];
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit p, input logic req, input logic we, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] d);
        if (!p) begin
            p0_req_i = req; p0_we_i = we; p0_width_i = w; p0_addr_i = a; p0_wdata_i = d;
        end else begin
            p1_req_i = req; p1_we_i = we; p1_width_i = w; p1_addr_i = a; p1_wdata_i = d;
        end
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, W32, 32'h0, 32'h0);
        drv(1'b1, 1'b0, 1'b0, W32, 32'h0, 32'h0);
        p1_lock_i = 1'b0;
    endtask

    function automatic bit is_bad(input logic [2:0] w, input logic [31:0] a);
        if (a >= DEPTH) return 1'b1;
        if (w == W32) return a[1:0] != 2'b00;
        if (w == W16) return a[0];
        return w != W8;
    endfunction

    typedef struct {
        bit          port;
        logic        we;
        logic [2:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input bit p, input logic we, input logic [2:0] w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic err, input logic [31:0] rd);
        vec_t v;
        v.port = p; v.we = we; v.w = w; v.a = a; v.d = d; v.err = err; v.rd = rd;
        return v;
    endfunction

    // Transaction-level model state
    bit          m_locked;
    int          m_streak;
    bit          exp_rv0, exp_rv1, exp_e0, exp_e1;
    logic [31:0] exp_rd0, exp_rd1;

    initial begin
        vec_t tbl[$];
        logic        g0, g1, e, gwe, pend0, pend1;
        logic [31:0] la;
        logic [9:0]  b;
        logic [2:0]  lw;
        logic [31:0] ldv;
        int          r;

        reset_i = 1'b1;
        idle();
        tick();
        tick();

        // Reset state: no grant and no write even with a store pending
        drv(1'b0, 1'b1, 1'b1, W32, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rst gnt0", p0_gnt_o, 0);
        chk("rst mem_we", mem_we_o, 0);
        chk("rst rvalid0", p0_rvalid_o, 0);
        chk("rst rvalid1", p1_rvalid_o, 0);
        chk("rst rdata0", p0_rdata_o, 0);
        chk("rst err1", p1_err_o, 0);
        tick();
        reset_i = 1'b0;
        idle();

        // Single isolated accesses
        tbl.push_back(mk(1, 1, W32, 32'h10,  32'hDEADBEEF, 0, 32'h0));
        tbl.push_back(mk(0, 0, W32, 32'h10,  32'h0,        0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, W32, 32'h20,  32'h8001F07F, 0, 32'h0));
        tbl.push_back(mk(0, 0, W16, 32'h22,  32'h0,        0, 32'hFFFF8001));
        tbl.push_back(mk(0, 0, W8,  32'h20,  32'h0,        0, 32'h0000007F));
        tbl.push_back(mk(1, 0, W8,  32'h21,  32'h0,        0, 32'hFFFFFFF0));
        tbl.push_back(mk(1, 1, W32, 32'h4,   32'h76543210, 0, 32'h0));
        tbl.push_back(mk(0, 1, W16, 32'h5,   32'h0000BEEF, 1, 32'h0));
        tbl.push_back(mk(1, 0, W32, 32'h4,   32'h0,        0, 32'h76543210));
        tbl.push_back(mk(1, 0, W32, 32'h400, 32'h0,        1, 32'h0));
        tbl.push_back(mk(1, 0, 3'b011, 32'h10, 32'h0,      1, 32'h0));
        tbl.push_back(mk(0, 0, W32, 32'h12,  32'h0,        1, 32'h0));
        tbl.push_back(mk(0, 1, W32, 32'h3FC, 32'hA5A55A5A, 0, 32'h0));
        tbl.push_back(mk(0, 0, W8,  32'h3FF, 32'h0,        0, 32'hFFFFFFA5));
        tbl.push_back(mk(0, 1, W8,  32'h3FE, 32'h12345600, 0, 32'h0));
        tbl.push_back(mk(0, 0, W32, 32'h3FC, 32'h0,        0, 32'hA5005A5A));
        tbl.push_back(mk(1, 0, W16, 32'h3FF, 32'h0,        1, 32'h0));
        tbl.push_back(mk(1, 1, W32, 32'h0,   32'h11223344, 0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            idle();
            drv(v.port, 1'b1, v.we, v.w, v.a, v.d);
            @(negedge clk);
            chk($sformatf("tbl%0d gnt", i), v.port ? p1_gnt_o : p0_gnt_o, 1);
            chk($sformatf("tbl%0d other gnt", i), v.port ? p0_gnt_o : p1_gnt_o, 0);
            chk($sformatf("tbl%0d mem_we", i), mem_we_o, v.we & ~v.err);
            chk($sformatf("tbl%0d mem_addr", i), mem_addr_o, v.a);
            tick();
            idle();
            @(negedge clk);
            chk($sformatf("tbl%0d rvalid", i), v.port ? p1_rvalid_o : p0_rvalid_o, 1);
            chk($sformatf("tbl%0d other rvalid", i), v.port ? p0_rvalid_o : p1_rvalid_o, 0);
            chk($sformatf("tbl%0d err", i), v.port ? p1_err_o : p0_err_o, v.err);
            chk($sformatf("tbl%0d rdata", i), v.port ? p1_rdata_o : p0_rdata_o, v.rd);
            tick();
        end

        // Both ports requesting continuously: four port-0 grants, then one port-1
        drv(1'b0, 1'b1, 1'b0, W32, 32'h10, 32'h0);
        drv(1'b1, 1'b1, 1'b0, W32, 32'h4, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("fair%0d gnt0", k), p0_gnt_o, (k % 5) != 4);
            chk($sformatf("fair%0d gnt1", k), p1_gnt_o, (k % 5) == 4);
            tick();
        end
        idle();
        tick();

        // Locked port-1 sequence with port 0 waiting
        drv(1'b1, 1'b1, 1'b1, W8, 32'h3, 32'h000000AB);
        p1_lock_i = 1'b1;
        @(negedge clk);
        chk("lockA gnt1", p1_gnt_o, 1);
        chk("lockA mem_we", mem_we_o, 1);
        tick();
        drv(1'b0, 1'b1, 1'b0, W32, 32'h10, 32'h0);
        drv(1'b1, 1'b1, 1'b0, W32, 32'h0, 32'h0);
        @(negedge clk);
        chk("lockB gnt1", p1_gnt_o, 1);
        chk("lockB gnt0", p0_gnt_o, 0);
        chk("lockB rvalid1", p1_rvalid_o, 1);
        tick();
        drv(1'b1, 1'b0, 1'b0, W32, 32'h0, 32'h0);
        p1_lock_i = 1'b0;
        @(negedge clk);
        chk("lockC gnt0", p0_gnt_o, 0);
        chk("lockC rdata1", p1_rdata_o, 32'hAB223344);
        tick();
        @(negedge clk);
        chk("lockD gnt0", p0_gnt_o, 1);
        tick();
        idle();
        @(negedge clk);
        chk("lockE rdata0", p0_rdata_o, 32'hDEADBEEF);
        tick();

        // Reset in the response cycle, with port 1 partly starved
        drv(1'b0, 1'b1, 1'b0, W32, 32'h10, 32'h0);
        drv(1'b1, 1'b1, 1'b0, W32, 32'h4, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("pre%0d gnt0", k), p0_gnt_o, 1);
            tick();
        end
        idle();
        reset_i = 1'b1;
        @(negedge clk);
        chk("rstmid rvalid0", p0_rvalid_o, 0);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        chk("rstpost rvalid0", p0_rvalid_o, 0);
        chk("rstpost rdata0", p0_rdata_o, 0);
        tick();
        drv(1'b0, 1'b1, 1'b0, W32, 32'h10, 32'h0);
        drv(1'b1, 1'b1, 1'b0, W32, 32'h4, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("post%0d gnt1", k), p1_gnt_o, k == 4);
            tick();
        end
        idle();
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        m_locked = 0; m_streak = 0;
        exp_rv0 = 0; exp_rv1 = 0; exp_e0 = 0; exp_e1 = 0;
        exp_rd0 = 0; exp_rd1 = 0;
        pend0 = 0; pend1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? !pend0 : !pend1) begin
                    r  = $urandom_range(0, 15);
                    lw = (r < 5) ? W32 : (r < 10) ? W16 : (r < 14) ? W8 :
                         3'($urandom_range(3, 7));
                    la = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 7))
                                                     : 32'($urandom_range(0, DEPTH - 1));
                    if ($urandom_range(0, 4) != 0) begin
                        if (lw == W32) la[1:0] = 2'b00;
                        if (lw == W16) la[0] = 1'b0;
                    end
                    drv(p[0], 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                        lw, la, $urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) p1_lock_i = ~p1_lock_i;

            g0 = 0; g1 = 0;
            if (m_locked) g1 = p1_req_i;
            else if (p1_req_i && (m_streak >= MAXW || !p0_req_i)) g1 = 1;
            else g0 = p0_req_i;
            la  = g1 ? p1_addr_i : p0_addr_i;
            lw  = g1 ? p1_width_i : p0_width_i;
            gwe = g1 ? p1_we_i : p0_we_i;
            e   = (g0 || g1) && is_bad(lw, la);

            @(negedge clk);
            chk($sformatf("rnd%0d gnt0", cyc), p0_gnt_o, g0);
            chk($sformatf("rnd%0d gnt1", cyc), p1_gnt_o, g1);
            chk($sformatf("rnd%0d mem_we", cyc), mem_we_o, (g0 || g1) && gwe && !e);
            chk($sformatf("rnd%0d rvalid0", cyc), p0_rvalid_o, exp_rv0);
            chk($sformatf("rnd%0d rvalid1", cyc), p1_rvalid_o, exp_rv1);
            chk($sformatf("rnd%0d err0", cyc), p0_err_o, exp_e0);
            chk($sformatf("rnd%0d err1", cyc), p1_err_o, exp_e1);
            if (exp_rv0) chk($sformatf("rnd%0d rdata0", cyc), p0_rdata_o, exp_rd0);
            if (exp_rv1) chk($sformatf("rnd%0d rdata1", cyc), p1_rdata_o, exp_rd1);

            ldv = 32'h0;
            b = la[9:0];
            if ((g0 || g1) && !e) begin
                if (gwe) begin
                    logic [31:0] d;
                    d = g1 ? p1_wdata_i : p0_wdata_i;
                    for (int k = 0; k < ((lw == W32) ? 4 : (lw == W16) ? 2 : 1); k++)
                        ref_mem[b + 10'(k)] = d[8*k +: 8];
                end else begin
                    ldv = ld(ref_mem[b], ref_mem[b + 10'd1], ref_mem[b + 10'd2],
                             ref_mem[b + 10'd3], lw);
                end
            end
            exp_rv0 = g0; exp_rv1 = g1;
            exp_e0 = g0 && e; exp_e1 = g1 && e;
            if (g0) exp_rd0 = ldv;
            if (g1) exp_rd1 = ldv;
            if (!p1_req_i || g1) m_streak = 0;
            else if (!m_locked) m_streak++;
            m_locked = m_locked ? p1_lock_i : (g1 && p1_lock_i);
            pend0 = p0_req_i && !g0;
            pend1 = p1_req_i && !g1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
